// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter that shares one sprite ROM read port among NUM_REQ requesters.
// Responses come back a fixed number of cycles after the grant and are tagged with the requester id.
module sprite_rom_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 8,
  parameter int ROM_LATENCY = 2
) (
  input  logic                          pixel_clk_in,
  input  logic                          rst_n_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic [ADDR_WIDTH-1:0]         rom_addr_out,
  input  logic [DATA_WIDTH-1:0]         rom_data_in,
  output logic [NUM_REQ-1:0]            resp_valid_out,
  output logic [DATA_WIDTH-1:0]         resp_data_out
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int DEPTH = 1 + ROM_LATENCY;

  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [DEPTH-1:0]      tag_vld_q, tag_vld_d;
  logic [ID_W-1:0]       tag_id_q [DEPTH];
  logic [ID_W-1:0]       tag_id_d [DEPTH];
  logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;

  logic                  grant_vld;
  logic [ID_W-1:0]       grant_id;
  logic [ID_W-1:0]       arb_idx;

  // Scan downward so the candidate closest to the pointer is the last one written.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    arb_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      arb_idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (req_valid_in[arb_idx]) begin
        grant_vld = 1'b1;
        grant_id  = arb_idx;
      end
    end
    if (!rst_n_in) begin
      grant_vld = 1'b0;
    end
    req_ready_out = grant_vld ? (NUM_REQ'(1) << grant_id) : '0;
  end

  always_comb begin
    ptr_d        = ptr_q;
    rom_addr_d   = rom_addr_q;
    tag_vld_d    = '0;
    resp_valid_d = '0;
    resp_data_d  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tag_id_d[i] = '0;
    end

    if (grant_vld) begin
      ptr_d      = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      rom_addr_d = req_addr_in[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Tag stage 0 lines up with the address register; the last stage lines up with ROM data.
    tag_vld_d[0] = grant_vld;
    tag_id_d[0]  = grant_id;
    for (int i = 1; i < DEPTH; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end

    if (tag_vld_q[DEPTH-1]) begin
      resp_valid_d = NUM_REQ'(1) << tag_id_q[DEPTH-1];
      resp_data_d  = rom_data_in;
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ptr_q        <= '0;
      rom_addr_q   <= '0;
      tag_vld_q    <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_id_q[i] <= '0;
      end
    end else begin
      ptr_q        <= ptr_d;
      rom_addr_q   <= rom_addr_d;
      tag_vld_q    <= tag_vld_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      for (int i = 0; i < DEPTH; i++) begin
        tag_id_q[i] <= tag_id_d[i];
      end
    end
  end

  assign rom_addr_out   = rom_addr_q;
  assign resp_valid_out = resp_valid_q;
  assign resp_data_out  = resp_data_q;

endmodule
